// File: rtl/alu_ctrl_md_if.sv
// EX-stage ALU bus: op decode inputs, operands, mult/div start, combinational result and HI/LO state.
// The datapath/controller is the master; the ALU is the slave.
interface alu_ctrl_md_if #(parameter int WIDTH = 32);
    logic [1:0]       alu_op;
    logic [5:0]       func;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             start;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             illegal;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output alu_op, func, a, b, start,
        input  result, zero, ovf, illegal, busy, done, hi, lo
    );

    modport slave (
        input  alu_op, func, a, b, start,
        output result, zero, ovf, illegal, busy, done, hi, lo
    );
endinterface

// File: rtl/alu_ctrl_md.sv
// MIPS ALU control + execute: zero-latency ALU ops; iterative mult/div taking WIDTH+1 cycles to done.
// No backpressure: start is only accepted in IDLE, and the controller stalls on busy.
module alu_ctrl_md #(
    parameter int WIDTH = 32
) (
    input logic           clk_i,
    input logic           rst_i,
    alu_ctrl_md_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [4:0] {
        OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLTU, OP_MFHI, OP_MFLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_ILL
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    op_e              op;
    logic [WIDTH-1:0] sum, diff, b_neg, res;
    logic             ovf;
    logic             is_md, md_signed, md_div;
    logic [WIDTH-1:0] a_abs, b_abs;

    state_e             state_q;
    logic [CW-1:0]      count_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, a_raw_q;
    logic               is_div_q, q_neg_q, r_neg_q, dz_q;
    logic [WIDTH-1:0]   hi_q, lo_q, hi_d, lo_d;
    logic               busy_q, done_q;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        op = OP_ILL;
        case (bus.alu_op)
            2'b00: op = OP_ADDU;
            2'b01: op = OP_SUBU;
            2'b10: begin
                case (bus.func)
                    6'h20: op = OP_ADD;
                    6'h21: op = OP_ADDU;
                    6'h22: op = OP_SUB;
                    6'h23: op = OP_SUBU;
                    6'h24: op = OP_AND;
                    6'h25: op = OP_OR;
                    6'h26: op = OP_XOR;
                    6'h27: op = OP_NOR;
                    6'h2A: op = OP_SLT;
                    6'h2B: op = OP_SLTU;
                    6'h10: op = OP_MFHI;
                    6'h12: op = OP_MFLO;
                    6'h18: op = OP_MULT;
                    6'h19: op = OP_MULTU;
                    6'h1A: op = OP_DIV;
                    6'h1B: op = OP_DIVU;
                    default: op = OP_ILL;
                endcase
            end
            default: op = OP_ILL;
        endcase
    end

    assign sum   = bus.a + bus.b;
    assign diff  = bus.a - bus.b;
    assign b_neg = ~bus.b + 1'b1;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (op)
            OP_ADD: begin
                res = sum;
                ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_ADDU: res = sum;
            OP_SUB: begin
                res = diff;
                ovf = (bus.a[WIDTH-1] == b_neg[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUBU: res = diff;
            OP_AND:  res = bus.a & bus.b;
            OP_OR:   res = bus.a | bus.b;
            OP_XOR:  res = bus.a ^ bus.b;
            OP_NOR:  res = ~(bus.a | bus.b);
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            OP_MFHI: res = hi_q;
            OP_MFLO: res = lo_q;
            default: res = '0;
        endcase
    end

    assign bus.result  = res;
    assign bus.zero    = (res == '0);
    assign bus.ovf     = ovf;
    assign bus.illegal = (op == OP_ILL);

    assign is_md     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign md_signed = (op == OP_MULT) || (op == OP_DIV);
    assign md_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign a_abs     = (md_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_abs     = (md_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Multiply: add multiplicand into the upper half, shift right. Divide: shift left, trial subtract.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
        if (is_div_q) begin
            if (!div_trial[WIDTH])
                acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod = q_neg_q ? -acc_d : acc_d;
        hi_d = prod[2*WIDTH-1:WIDTH];
        lo_d = prod[WIDTH-1:0];
        if (is_div_q) begin
            if (dz_q) begin
                hi_d = a_raw_q;
                lo_d = '1;
            end else begin
                lo_d = q_neg_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
                hi_d = r_neg_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_raw_q  <= '0;
            is_div_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start && is_md) begin
                        state_q  <= S_RUN;
                        busy_q   <= 1'b1;
                        count_q  <= '0;
                        is_div_q <= md_div;
                        a_raw_q  <= bus.a;
                        dz_q     <= (bus.b == '0);
                        q_neg_q  <= md_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_neg_q  <= md_signed && md_div && bus.a[WIDTH-1];
                        acc_q    <= {{WIDTH{1'b0}}, md_div ? a_abs : b_abs};
                        opnd_q   <= md_div ? b_abs : a_abs;
                    end
                end
                S_RUN: begin
                    acc_q   <= acc_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(WIDTH-1)) begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_alu_ctrl_md.sv
// Directed bench for alu_ctrl_md: combinational decode vectors, then mult/div runs with handshake timing.
module tb_alu_ctrl_md;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_ctrl_md_if #(.WIDTH(W)) bus ();
    alu_ctrl_md #(.WIDTH(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        il;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    // Runs one mult/div op; optionally re-pulses start or asserts rst at a given busy cycle.
    task automatic run_md(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                          input int repulse, input int rst_at,
                          output int nbusy, output int done_k, output int ndone,
                          output logic [31:0] hi_v, output logic [31:0] lo_v);
        @(negedge clk);
        bus.alu_op = 2'b10;
        bus.func   = f;
        bus.a      = av;
        bus.b      = bv;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 32'h1234_5678;
        bus.b     = 32'h0;
        nbusy = 0; done_k = 0; ndone = 0; hi_v = '0; lo_v = '0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.busy === 1'b1) nbusy++;
            if (bus.done === 1'b1) begin
                ndone++;
                done_k = k;
                hi_v = bus.hi;
                lo_v = bus.lo;
                if (bus.busy !== 1'b0) begin
                    errors++;
                    checks++;
                    $display("FAIL busy_with_done: got busy=%b required 0", bus.busy);
                end
            end
            bus.start = (k == repulse);
            rst = (k == rst_at);
            @(negedge clk);
        end
        bus.start = 1'b0;
        rst = 1'b0;
    endtask

    int nbusy, done_k, ndone, bcount;
    logic [31:0] hi_v, lo_v;

    initial begin
        vecs = '{
            '{2'b10, 6'h22, 32'd5,        32'd5,        32'h0000_0000, 1'b1, 1'b0, 1'b0},
            '{2'b10, 6'h20, 32'h7FFF_FFFF, 32'd1,       32'h8000_0000, 1'b0, 1'b1, 1'b0},
            '{2'b10, 6'h21, 32'h7FFF_FFFF, 32'd1,       32'h8000_0000, 1'b0, 1'b0, 1'b0},
            '{2'b10, 6'h22, 32'h8000_0000, 32'd1,       32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0},
            '{2'b10, 6'h23, 32'h8000_0000, 32'd1,       32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0},
            '{2'b10, 6'h20, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0},
            '{2'b00, 6'h3F, 32'd3,        32'd4,        32'h0000_0007, 1'b0, 1'b0, 1'b0},
            '{2'b01, 6'h3F, 32'd3,        32'd4,        32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0},
            '{2'b10, 6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0},
            '{2'b10, 6'h25, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0},
            '{2'b10, 6'h26, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0},
            '{2'b10, 6'h27, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0, 1'b0, 1'b0},
            '{2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1,       32'h0000_0001, 1'b0, 1'b0, 1'b0},
            '{2'b10, 6'h2B, 32'hFFFF_FFFF, 32'd1,       32'h0000_0000, 1'b1, 1'b0, 1'b0},
            '{2'b10, 6'h18, 32'd5,        32'd5,        32'h0000_0000, 1'b1, 1'b0, 1'b0},
            '{2'b11, 6'h20, 32'd5,        32'd6,        32'h0000_0000, 1'b1, 1'b0, 1'b1},
            '{2'b10, 6'h3F, 32'd5,        32'd6,        32'h0000_0000, 1'b1, 1'b0, 1'b1}
        };

        rst = 1'b1;
        bus.alu_op = 2'b10; bus.func = 6'h22; bus.a = 32'd5; bus.b = 32'd5; bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);

        for (int i = 0; i < NV; i++) begin
            bus.alu_op = vecs[i].op; bus.func = vecs[i].f; bus.a = vecs[i].a; bus.b = vecs[i].b;
            #1;
            check($sformatf("comb%0d", i),
                  {29'd0, bus.result, bus.zero, bus.ovf, bus.illegal},
                  {29'd0, vecs[i].res, vecs[i].z, vecs[i].o, vecs[i].il});
        end

        run_md(6'h18, 32'hFFFF_FFFD, 32'd7, 0, 0, nbusy, done_k, ndone, hi_v, lo_v);
        check("mult_busy", 64'(nbusy), 64'd32);
        check("mult_done_cycle", 64'(done_k), 64'd33);
        check("mult_ndone", 64'(ndone), 64'd1);
        check("mult_hilo", {hi_v, lo_v}, 64'hFFFF_FFFF_FFFF_FFEB);
        bus.func = 6'h12; #1;
        check("mflo", {32'd0, bus.result}, 64'h0000_0000_FFFF_FFEB);
        bus.func = 6'h10; #1;
        check("mfhi", {32'd0, bus.result}, 64'h0000_0000_FFFF_FFFF);

        run_md(6'h1A, 32'hFFFF_FFF9, 32'd2, 0, 0, nbusy, done_k, ndone, hi_v, lo_v);
        check("div_neg", {hi_v, lo_v}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_md(6'h1B, 32'd10, 32'd0, 0, 0, nbusy, done_k, ndone, hi_v, lo_v);
        check("divu_by0", {hi_v, lo_v}, 64'h0000_000A_FFFF_FFFF);
        run_md(6'h1A, 32'hFFFF_FFFB, 32'd0, 0, 0, nbusy, done_k, ndone, hi_v, lo_v);
        check("div_by0", {hi_v, lo_v}, 64'hFFFF_FFFB_FFFF_FFFF);
        run_md(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, nbusy, done_k, ndone, hi_v, lo_v);
        check("div_ovf", {hi_v, lo_v}, 64'h0000_0000_8000_0000);
        run_md(6'h1B, 32'd100, 32'd7, 0, 0, nbusy, done_k, ndone, hi_v, lo_v);
        check("divu_100_7", {hi_v, lo_v}, 64'h0000_0002_0000_000E);
        run_md(6'h1A, 32'd7, 32'hFFFF_FFFE, 0, 0, nbusy, done_k, ndone, hi_v, lo_v);
        check("div_pos_neg", {hi_v, lo_v}, 64'h0000_0001_FFFF_FFFD);

        run_md(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 0, nbusy, done_k, ndone, hi_v, lo_v);
        check("multu_busy", 64'(nbusy), 64'd32);
        check("multu_done_cycle", 64'(done_k), 64'd33);
        check("multu_ndone", 64'(ndone), 64'd1);
        check("multu_hilo", {hi_v, lo_v}, 64'hFFFF_FFFE_0000_0001);

        run_md(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 10, nbusy, done_k, ndone, hi_v, lo_v);
        check("abort_busy", 64'(nbusy), 64'd10);
        check("abort_ndone", 64'(ndone), 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        check("abort_idle", {63'd0, bus.busy}, 64'd0);

        @(negedge clk);
        bus.alu_op = 2'b11; bus.func = 6'h18; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bcount = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.busy !== 1'b0) bcount++;
            @(negedge clk);
        end
        check("illegal_start", 64'(bcount), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
